// File: rtl/sdc_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sdc_pkg : shared constants, error codes and FSM encoding (rev 1.0) |
// +--------------------------------------------------------------------+
package sdc_pkg;

  localparam logic [7:0] CMD17       = 8'h51;
  localparam logic [7:0] TOKEN_START = 8'hFE;
  localparam logic [7:0] FILL_BYTE   = 8'hFF;
  localparam int         BLOCK_BYTES = 512;

  localparam logic [1:0] ERR_NONE      = 2'd0;
  localparam logic [1:0] ERR_R1_TO     = 2'd1;
  localparam logic [1:0] ERR_R1_BAD    = 2'd2;
  localparam logic [1:0] ERR_TOKEN_ERR = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CMD   = 3'd1,
    ST_R1    = 3'd2,
    ST_TOKEN = 3'd3,
    ST_DATA  = 3'd4,
    ST_CRC   = 3'd5,
    ST_TRAIL = 3'd6,
    ST_DONE  = 3'd7
  } state_t;

  // CMD17 frame: opcode, 4 address bytes MSB first, dummy CRC.
  function automatic logic [7:0] cmd_byte(input logic [2:0] idx, input logic [31:0] addr);
    case (idx)
      3'd0:    cmd_byte = CMD17;
      3'd1:    cmd_byte = addr[31:24];
      3'd2:    cmd_byte = addr[23:16];
      3'd3:    cmd_byte = addr[15:8];
      3'd4:    cmd_byte = addr[7:0];
      default: cmd_byte = FILL_BYTE;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/sdc_block_read_spi_byte_xfer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | spi_byte_xfer : one mode-0 SPI byte, MSB first (rev 1.0)           |
// +--------------------------------------------------------------------+
module spi_byte_xfer #(
  parameter int CLK_DIV = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_we,
  input  logic [7:0] i_tx,
  input  logic       i_miso,
  output logic       o_mosi,
  output logic       o_sck,
  output logic [7:0] o_rx,
  output logic       o_done
);

  localparam int            DW       = $clog2(CLK_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  logic          r_busy;
  logic [DW-1:0] r_div;
  logic [3:0]    r_half;
  logic          r_sck;
  logic [7:0]    r_tx;
  logic [7:0]    r_rx;
  logic          r_done;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_busy <= 1'b0;
      r_div  <= '0;
      r_half <= '0;
      r_sck  <= 1'b0;
      r_tx   <= 8'hFF;
      r_rx   <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (!r_busy) begin
        if (i_we) begin
          r_busy <= 1'b1;
          r_tx   <= i_tx;
          r_div  <= '0;
          r_half <= '0;
          r_sck  <= 1'b0;
        end
      end else if (r_div != DIV_LAST) begin
        r_div <= r_div + 1'b1;
      end else begin
        r_div  <= '0;
        r_half <= r_half + 4'd1;
        r_sck  <= ~r_sck;
        // Sample on the rising edge, shift the next MOSI bit on the falling edge.
        if (!r_sck) begin
          r_rx <= {r_rx[6:0], i_miso};
        end else begin
          r_tx <= {r_tx[6:0], 1'b1};
          if (r_half == 4'd15) begin
            r_busy <= 1'b0;
            r_done <= 1'b1;
          end
        end
      end
    end
  end

  assign o_mosi = r_busy ? r_tx[7] : 1'b1;
  assign o_sck  = r_sck;
  assign o_rx   = r_rx;
  assign o_done = r_done;

endmodule
`default_nettype wire

// File: rtl/sdc_block_read.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sdc_block_read : CMD17 single-block SD read over SPI (rev 1.0)     |
// +--------------------------------------------------------------------+
module sdc_block_read
  import sdc_pkg::*;
#(
  parameter int CLK_DIV    = 4,
  parameter int R1_POLL    = 8,
  parameter int TOKEN_POLL = 1024
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic [31:0] i_addr,
  input  logic        i_miso,
  output logic        o_mosi,
  output logic        o_cs,
  output logic        o_sck,
  output logic        o_busy,
  output logic [7:0]  o_data,
  output logic        o_valid,
  output logic        o_done,
  output logic        o_err,
  output logic [1:0]  o_err_code
);

  localparam int POLL_MAX = (TOKEN_POLL > R1_POLL) ? TOKEN_POLL : R1_POLL;
  localparam int CNT_W    = $clog2(POLL_MAX + 8);

  localparam logic [CNT_W-1:0] R1_LAST   = CNT_W'(R1_POLL - 1);
  localparam logic [CNT_W-1:0] TOK_LAST  = CNT_W'(TOKEN_POLL - 1);
  localparam logic [CNT_W-1:0] CMD_LAST  = CNT_W'(5);
  localparam logic [CNT_W-1:0] CRC_LAST  = CNT_W'(1);
  localparam logic [9:0]       DATA_LAST = 10'(BLOCK_BYTES - 1);

  state_t           r_state;
  state_t           w_next;
  logic [31:0]      r_addr;
  logic [CNT_W-1:0] r_cnt;
  logic [9:0]       r_byte_cnt;
  logic             r_pend;
  logic [1:0]       r_err_pend;
  logic             r_cs;
  logic             r_busy;
  logic [7:0]       r_data;
  logic             r_valid;
  logic             r_done;
  logic             r_err;
  logic [1:0]       r_err_code;

  logic             w_we;
  logic [7:0]       w_tx;
  logic             w_err_set;
  logic [1:0]       w_err_val;
  logic             w_accept;
  logic [7:0]       w_rx;
  logic             w_xdone;

  spi_byte_xfer #(
    .CLK_DIV (CLK_DIV)
  ) u_xfer (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_we   (w_we),
    .i_tx   (w_tx),
    .i_miso (i_miso),
    .o_mosi (o_mosi),
    .o_sck  (o_sck),
    .o_rx   (w_rx),
    .o_done (w_xdone)
  );

  assign w_accept = (r_state == ST_IDLE) && i_start;

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_we      = 1'b0;
    w_tx      = FILL_BYTE;
    w_err_set = 1'b0;
    w_err_val = ERR_NONE;
    case (r_state)
      ST_IDLE: if (i_start) w_next = ST_CMD;
      ST_DONE: w_next = ST_IDLE;
      default: begin
        // Every byte-level state issues one byte at a time and decides on its completion.
        w_we = !r_pend;
        if (r_state == ST_CMD) w_tx = cmd_byte(r_cnt[2:0], r_addr);
        if (w_xdone) begin
          case (r_state)
            ST_CMD: if (r_cnt == CMD_LAST) w_next = ST_R1;
            ST_R1: begin
              if (!w_rx[7]) begin
                if (w_rx == 8'h00) begin
                  w_next = ST_TOKEN;
                end else begin
                  w_next    = ST_TRAIL;
                  w_err_set = 1'b1;
                  w_err_val = ERR_R1_BAD;
                end
              end else if (r_cnt == R1_LAST) begin
                w_next    = ST_TRAIL;
                w_err_set = 1'b1;
                w_err_val = ERR_R1_TO;
              end
            end
            ST_TOKEN: begin
              if (w_rx == TOKEN_START) begin
                w_next = ST_DATA;
              end else if ((w_rx != FILL_BYTE) || (r_cnt == TOK_LAST)) begin
                w_next    = ST_TRAIL;
                w_err_set = 1'b1;
                w_err_val = ERR_TOKEN_ERR;
              end
            end
            ST_DATA:  if (r_byte_cnt == DATA_LAST) w_next = ST_CRC;
            ST_CRC:   if (r_cnt == CRC_LAST) w_next = ST_TRAIL;
            ST_TRAIL: w_next = ST_DONE;
            default:  w_next = r_state;
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_addr     <= '0;
      r_cnt      <= '0;
      r_byte_cnt <= '0;
      r_pend     <= 1'b0;
      r_err_pend <= ERR_NONE;
      r_cs       <= 1'b1;
      r_busy     <= 1'b0;
      r_data     <= '0;
      r_valid    <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_err_code <= ERR_NONE;
    end else begin
      r_valid <= 1'b0;
      r_done  <= (w_next == ST_DONE);
      r_busy  <= !((w_next == ST_IDLE) || (w_next == ST_DONE));
      // CS is released before the trailing byte so the card frees its DO line.
      r_cs    <= !(w_next inside {ST_CMD, ST_R1, ST_TOKEN, ST_DATA, ST_CRC});

      if (w_we)         r_pend <= 1'b1;
      else if (w_xdone) r_pend <= 1'b0;

      if (w_next != r_state) r_cnt <= '0;
      else if (w_xdone)      r_cnt <= r_cnt + 1'b1;

      if (w_accept) begin
        r_addr     <= i_addr;
        r_err      <= 1'b0;
        r_err_code <= ERR_NONE;
        r_err_pend <= ERR_NONE;
        r_byte_cnt <= '0;
      end

      if (w_err_set) r_err_pend <= w_err_val;

      if ((r_state == ST_DATA) && w_xdone) begin
        r_valid <= 1'b1;
        r_data  <= w_rx;
        if (r_byte_cnt != DATA_LAST) r_byte_cnt <= r_byte_cnt + 10'd1;
      end

      if (w_next == ST_DONE) begin
        r_err      <= (r_err_pend != ERR_NONE);
        r_err_code <= r_err_pend;
      end
    end
  end

  assign o_cs       = r_cs;
  assign o_busy     = r_busy;
  assign o_data     = r_data;
  assign o_valid    = r_valid;
  assign o_done     = r_done;
  assign o_err      = r_err;
  assign o_err_code = r_err_code;

endmodule
`default_nettype wire

// File: doc/sdc_block_read.md
Name: sdc_block_read

Overview:
- Downstream of the SD card SPI init sequencer; runs only after init reports done.
- Reads one 512-byte block with CMD17 (SDHC block addressing) and streams the payload out one byte per strobe to the consumer (FIFO/display/UART).
- Contains its own SPI bit engine, so it drives CS/SCK/MOSI directly. The top level muxes these pins between init and this block.

Parameters:
- CLK_DIV, 4, i_clk cycles per SCK half-period (>=2).
- R1_POLL, 8, max 0xFF-filler bytes polled for the R1 response.
- TOKEN_POLL, 1024, max bytes polled for the data start token.

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  synchronous, active-high reset
- i_start  in  1  one-cycle request; accepted only when idle
- i_addr  in  32  block address, sampled when i_start is accepted
- i_miso  in  1  card data out
- o_mosi  out  1  card data in
- o_cs  out  1  chip select, active low
- o_sck  out  1  SPI clock, mode 0
- o_busy  out  1  high from accept until the o_done cycle
- o_data  out  8  payload byte, valid with o_valid
- o_valid  out  1  one-cycle strobe per payload byte
- o_done  out  1  one-cycle pulse at the end of a transaction (success or error)
- o_err  out  1  error flag, valid from o_done until next accept
- o_err_code  out  2  0 none, 1 R1 timeout, 2 R1 nonzero, 3 token timeout or error token

Behaviour:
- Reset values: o_cs=1, o_mosi=1, o_sck=0, o_busy=0, o_data=0, o_valid=0, o_done=0, o_err=0, o_err_code=0. All counters are zero and the FSM is in IDLE.
- Reset mid-operation: the next cycle shows the reset values. No further o_valid and no o_done are produced.
- SPI timing, mode 0:
  - MOSI is updated while SCK is low.
  - MISO is sampled on the SCK rising edge.
  - MSB first.
  - One byte takes 16*CLK_DIV i_clk cycles.
  - MOSI=1 whenever no command bit is being sent.
- Accept: IDLE and i_start -> latch i_addr, clear o_err/o_err_code, o_busy=1, o_cs=0 on the next cycle. i_start is ignored while o_busy=1.
- FSM states and transitions:
  - IDLE.
  - CMD: sends 6 bytes 0x51, addr[31:24], [23:16], [15:8], [7:0], 0xFF (CRC unused).
  - R1: sends 0xFF and polls.
    - rx[7]=0 -> check the byte: 0x00 -> TOKEN; otherwise finish with err 2.
    - No such byte after R1_POLL bytes -> finish with err 1.
  - TOKEN: sends 0xFF and polls.
    - 0xFE -> DATA.
    - 0xFF -> keep polling.
    - Any other value (error token) -> finish with err 3.
    - TOKEN_POLL bytes exhausted -> finish with err 3.
  - DATA: 512 bytes. Each received byte drives o_data and pulses o_valid for one cycle, one cycle after the byte engine completes. The byte counter is 10 bits and stops at 511.
  - CRC: 2 bytes, received and discarded (no o_valid).
  - TRAIL: o_cs=1, then one 0xFF byte of 8 SCK clocks to release the card's DO line.
  - DONE: o_done=1 for one cycle, o_busy drops in the same cycle, return to IDLE.
- Error finishes go through TRAIL then DONE, with o_err=1 and o_err_code set at the o_done cycle.
- A success finish leaves o_err=0.
- o_valid is never asserted outside DATA. Exactly 512 o_valid pulses occur on success.

Decomposition:
- Package sdc_pkg holds:
  - CMD17 = 8'h51, TOKEN_START = 8'hFE, BLOCK_BYTES = 512.
  - The err_code constants (NONE, R1_TO, R1_BAD, TOKEN_ERR).
  - The FSM state encoding.
- Sub-module spi_byte_xfer (CLK_DIV):
  - Inputs: i_clk, i_rst, i_we, i_tx[7:0], i_miso.
  - Outputs: o_mosi, o_sck, o_rx[7:0], o_done (one-cycle pulse).
  - It is reused by the future write-block stage.

Test Plan:
- Normal read, CLK_DIV=4, i_addr=0x00000010. Card model gives 2 bytes of 0xFF, then R1 0x00, then 3 bytes of 0xFF, then 0xFE, then data[i]=i mod 256, then CRC 0xAB 0xCD.
  -> MOSI command bytes are 51 00 00 00 10 FF.
  -> 512 o_valid pulses with data 0x00..0xFF repeated twice.
  -> o_done with o_err=0.
  -> o_cs=1 before the final 8 SCK clocks.
- MISO stuck at 1 -> after 6 command bytes plus 8 poll bytes: o_done, o_err=1, o_err_code=1, zero o_valid.
- R1 = 0x05 -> o_done, o_err_code=2, zero o_valid, no token polling bytes.
- Error token 0x09 after R1 0x00 -> o_done, o_err_code=3. Also with TOKEN_POLL=16 and MISO 0xFF -> err 3 after 16 poll bytes.
- Assert i_rst for one cycle after the 100th o_valid -> next cycle o_cs=1, o_sck=0, o_busy=0; no further o_valid and no o_done. A fresh i_start then completes the normal read.
- i_start pulsed while busy with a different i_addr -> ignored; command bytes carry the first address; exactly one o_done.
